// File: rtl/reg_scoreboard.sv
// Register scoreboard at the decode/execute boundary: decodes the instruction in decode,
// tracks pending multi-cycle writes per register, and stalls on RAW/WAW/multdiv hazards.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int LW_LAT   = 1,
    parameter int MD_LAT   = 17,
    parameter int CNT_W    = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [31:0]         issue_instr,
    input  logic                flush,
    output logic                stall,
    output logic                issue_fire,
    output logic                reads_a,
    output logic                reads_b,
    output logic                writes_dst,
    output logic [4:0]          dst_reg,
    output logic [NUM_REGS-1:0] busy_mask
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] OP_BEQ  = 5'b11001;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic                md_inflight_q, md_inflight_d;
    logic [4:0]          md_reg_q, md_reg_d;

    logic [4:0]       opcode, rd, rs, rt, aluop, src_b;
    logic             is_lw, is_md, raw, waw, mds;
    logic [CNT_W-1:0] lat;
    logic             unused_bits;

    assign opcode      = issue_instr[31:27];
    assign rd          = issue_instr[26:22];
    assign rs          = issue_instr[21:17];
    assign rt          = issue_instr[16:12];
    assign aluop       = issue_instr[6:2];
    assign unused_bits = ^{issue_instr[11:7], issue_instr[1:0]};

    always_comb begin
        reads_a    = 1'b0;
        reads_b    = 1'b0;
        src_b      = 5'd0;
        writes_dst = 1'b0;
        dst_reg    = 5'd0;
        case (opcode)
            OP_R: begin
                reads_a = 1'b1; reads_b = 1'b1; src_b = rt;
                writes_dst = 1'b1; dst_reg = rd;
            end
            OP_ADDI, OP_LW: begin
                reads_a = 1'b1; writes_dst = 1'b1; dst_reg = rd;
            end
            OP_SW, OP_BNE, OP_BLT, OP_BEQ: begin
                reads_a = 1'b1; reads_b = 1'b1; src_b = rd;
            end
            OP_JR:   begin reads_b = 1'b1; src_b = rd; end
            OP_BEX:  begin reads_b = 1'b1; src_b = 5'd30; end
            OP_JAL:  begin writes_dst = 1'b1; dst_reg = 5'd31; end
            OP_SETX: begin writes_dst = 1'b1; dst_reg = 5'd30; end
            default: ;
        endcase
    end

    always_comb begin
        is_lw = (opcode == OP_LW);
        is_md = (opcode == OP_R) && (aluop == ALU_MUL || aluop == ALU_DIV);
        if (is_lw)      lat = CNT_W'(LW_LAT);
        else if (is_md) lat = CNT_W'(MD_LAT);
        else            lat = '0;

        raw = (reads_a && rs != 5'd0 && busy_q[rs]) ||
              (reads_b && src_b != 5'd0 && busy_q[src_b]);
        waw = writes_dst && dst_reg != 5'd0 && busy_q[dst_reg];
        mds = is_md && md_inflight_q;

        stall      = issue_valid && (raw || waw || mds);
        issue_fire = issue_valid && !stall;
    end

    always_comb begin
        busy_d        = busy_q;
        cnt_d         = cnt_q;
        md_inflight_d = md_inflight_q;
        md_reg_d      = md_reg_q;

        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (busy_q[i]) begin
                if (cnt_q[i] == CNT_W'(1)) begin
                    busy_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end

        // The multdiv flag retires with the register it guards; MDS keeps a new mark from colliding.
        if (md_inflight_q && busy_q[md_reg_q] && cnt_q[md_reg_q] == CNT_W'(1))
            md_inflight_d = 1'b0;

        if (issue_fire && lat != '0 && dst_reg != 5'd0) begin
            busy_d[dst_reg] = 1'b1;
            cnt_d[dst_reg]  = lat;
            if (is_md) begin
                md_inflight_d = 1'b1;
                md_reg_d      = dst_reg;
            end
        end

        if (flush) begin
            busy_d        = '0;
            md_inflight_d = 1'b0;
            md_reg_d      = 5'd0;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q        <= '0;
            md_inflight_q <= 1'b0;
            md_reg_q      <= 5'd0;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            busy_q        <= busy_d;
            md_inflight_q <= md_inflight_d;
            md_reg_q      <= md_reg_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign busy_mask = busy_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: lw/mul latencies, RAW/WAW/MDS stalls, flush and async reset.
module tb_reg_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_instr = '0;
    logic        flush = 1'b0;
    logic        stall, issue_fire, reads_a, reads_b, writes_dst;
    logic [4:0]  dst_reg;
    logic [31:0] busy_mask;

    int tests_run = 0;
    int tests_failed = 0;
    int n;

    reg_scoreboard #(.NUM_REGS(32), .LW_LAT(1), .MD_LAT(17), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_instr(issue_instr),
        .flush(flush), .stall(stall), .issue_fire(issue_fire), .reads_a(reads_a),
        .reads_b(reads_b), .writes_dst(writes_dst), .dst_reg(dst_reg), .busy_mask(busy_mask)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rd, rs, rt, aluop);
        return {5'b00000, rd, rs, rt, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] i_op(input logic [4:0] op, rd, rs);
        return {op, rd, rs, 17'd0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic present(input logic v, input logic [31:0] ins);
        issue_valid = v;
        issue_instr = ins;
        #1;
    endtask

    initial begin
        tick();
        tick();
        check_eq("rst_busy", busy_mask, 32'h0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: lw r5 then add r6,r5,r7
        present(1'b1, i_op(5'b01000, 5'd5, 5'd1));
        check_eq("lw_fire", {31'd0, issue_fire}, 32'd1);
        check_eq("lw_dst", {27'd0, dst_reg}, 32'd5);
        check_eq("lw_reads", {30'd0, reads_a, reads_b}, 32'b10);
        tick();
        check_eq("lw_busy", busy_mask, 32'h20);
        present(1'b1, r_op(5'd6, 5'd5, 5'd7, 5'd0));
        check_eq("add_raw_stall", {31'd0, stall}, 32'd1);
        present(1'b0, r_op(5'd6, 5'd5, 5'd7, 5'd0));
        check_eq("novalid_nostall", {31'd0, stall}, 32'd0);
        present(1'b1, r_op(5'd6, 5'd5, 5'd7, 5'd0));
        tick();
        check_eq("lw_cleared", busy_mask, 32'h0);
        check_eq("add_fires", {31'd0, issue_fire}, 32'd1);
        tick();
        check_eq("add_unmarked", busy_mask, 32'h0);

        // 2: mul r3 then dependents
        present(1'b1, r_op(5'd3, 5'd1, 5'd2, 5'b00110));
        check_eq("mul_fire", {31'd0, issue_fire}, 32'd1);
        tick();
        check_eq("mul_busy", busy_mask, 32'h8);
        present(1'b1, r_op(5'd8, 5'd3, 5'd0, 5'd0));
        check_eq("add_r3_stall", {31'd0, stall}, 32'd1);
        present(1'b1, r_op(5'd4, 5'd1, 5'd2, 5'b00111));
        n = 0;
        while (stall && n < 40) begin
            n++;
            tick();
            #1;
        end
        check_eq("mds_cycles", n, 32'd17);
        check_eq("mul2_fire", {31'd0, issue_fire}, 32'd1);
        check_eq("r3_cleared", busy_mask, 32'h0);
        tick();
        check_eq("div_busy", busy_mask, 32'h10);

        // 5: flush with mul pending and lw firing
        flush = 1'b1;
        present(1'b1, i_op(5'b01000, 5'd9, 5'd1));
        check_eq("flush_lw_fire", {31'd0, issue_fire}, 32'd1);
        tick();
        flush = 1'b0;
        check_eq("flush_clear", busy_mask, 32'h0);
        present(1'b1, r_op(5'd10, 5'd1, 5'd2, 5'b00110));
        check_eq("flush_md_clear", {31'd0, stall}, 32'd0);
        tick();
        check_eq("mul10_busy", busy_mask, 32'h400);

        // 6: async reset mid-countdown (counter = 8 after 9 more edges)
        present(1'b0, 32'd0);
        for (int k = 0; k < 9; k++) tick();
        check_eq("mul10_still", busy_mask, 32'h400);
        #1 reset = 1'b1;
        #1;
        check_eq("async_rst", busy_mask, 32'h0);
        tick();
        reset = 1'b0;
        present(1'b1, r_op(5'd4, 5'd1, 5'd2, 5'b00110));
        check_eq("post_rst_mul", {31'd0, stall}, 32'd0);
        tick();
        present(1'b0, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // 3: r0 destinations, bex on r30
        present(1'b1, i_op(5'b01000, 5'd0, 5'd1));
        check_eq("lw_r0_wr", {31'd0, writes_dst}, 32'd1);
        tick();
        check_eq("lw_r0_unmarked", busy_mask, 32'h0);
        present(1'b1, r_op(5'd0, 5'd0, 5'd0, 5'b00110));
        check_eq("mul_r0_nostall", {31'd0, stall}, 32'd0);
        tick();
        check_eq("mul_r0_unmarked", busy_mask, 32'h0);
        present(1'b1, i_op(5'b00011, 5'd7, 5'd7));
        check_eq("jal_dst", {27'd0, dst_reg}, 32'd31);
        present(1'b1, i_op(5'b10101, 5'd7, 5'd7));
        check_eq("setx_dst", {27'd0, dst_reg}, 32'd30);
        present(1'b1, i_op(5'b00010, 5'd7, 5'd7));
        check_eq("bne_nowrite", {26'd0, writes_dst, dst_reg}, 32'd0);
        present(1'b1, i_op(5'b01000, 5'd30, 5'd1));
        tick();
        present(1'b1, i_op(5'b10110, 5'd0, 5'd0));
        check_eq("bex_decode", {30'd0, reads_a, reads_b}, 32'b01);
        check_eq("bex_stall", {31'd0, stall}, 32'd1);
        tick();
        check_eq("bex_fire", {31'd0, issue_fire}, 32'd1);

        // 4: lw r9, sw reads rd=r9, WAW on lw r9; same-edge clear r9 / set r6
        present(1'b1, i_op(5'b01000, 5'd9, 5'd1));
        tick();
        present(1'b1, i_op(5'b00111, 5'd9, 5'd1));
        check_eq("sw_raw_stall", {31'd0, stall}, 32'd1);
        present(1'b1, i_op(5'b01000, 5'd9, 5'd1));
        check_eq("lw_waw_stall", {31'd0, stall}, 32'd1);
        present(1'b1, i_op(5'b01000, 5'd6, 5'd1));
        check_eq("lw6_fire", {31'd0, issue_fire}, 32'd1);
        tick();
        check_eq("same_edge", busy_mask, 32'h40);
        present(1'b1, i_op(5'b01000, 5'd9, 5'd1));
        check_eq("lw9_after", {31'd0, stall}, 32'd0);
        tick();
        present(1'b0, 32'd0);
        check_eq("lw9_busy", busy_mask, 32'h200);
        tick();
        check_eq("final_clear", busy_mask, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
